// File: rtl/lane_merge_pkg.sv
// rtl/lane_merge_pkg.sv - shared types for the two-lane merge arbiter
// Contents: lane count, lane identifier enum, merged beat struct, lane toggle helper.
package lane_merge_pkg;

  localparam int NUM_LANES = 2;
  localparam int BEAT_DATA_W = 5;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_t;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    lane_t                  lane;
  } beat_t;

  function automatic lane_t other_lane(input lane_t l);
    return (l == LANE0) ? LANE1 : LANE0;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// rtl/lane_fifo.sv - per-lane FIFO with registered not-full ready and no bypass
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   in_data_i/valid_i   upstream beat; in_ready_o is registered (count != DEPTH)
//   head_data_o/valid_o oldest stored beat; valid only from registered count
//   pop_i               consume the head (ignored when empty)
module lane_fifo
  import lane_merge_pkg::*;
#(
  parameter int DATA_WIDTH = BEAT_DATA_W,
  parameter int DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic                  head_valid_o,
  input  logic                  pop_i
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  ready_q;
  logic                  push, pop;

  always_comb begin
    push    = in_valid_i && ready_q;
    pop     = pop_i && (count_q != '0);
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_d;
      // Looking at the next count lets a popped-full FIFO reopen one cycle later.
      ready_q <= (count_d != FULL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= in_data_i;
  end

  assign in_ready_o   = ready_q;
  assign head_data_o  = mem_q[rd_q];
  assign head_valid_o = (count_q != '0);

endmodule

// File: rtl/lane_merge_arbiter.sv
// rtl/lane_merge_arbiter.sv - merges two ready/valid lanes onto one lane-tagged stream
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   I_k_data/valid/ready       input lane k (k = 0, 1), ready is registered
//   O_data/lane/valid, O_ready merged registered output with source lane
module lane_merge_arbiter
  import lane_merge_pkg::*;
#(
  parameter int DATA_WIDTH = BEAT_DATA_W,
  parameter int DEPTH      = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] I_0_data,
  input  logic                  I_0_valid,
  output logic                  I_0_ready,
  input  logic [DATA_WIDTH-1:0] I_1_data,
  input  logic                  I_1_valid,
  output logic                  I_1_ready,
  output logic [DATA_WIDTH-1:0] O_data,
  output logic                  O_lane,
  output logic                  O_valid,
  input  logic                  O_ready
);

  logic [DATA_WIDTH-1:0] head0_data, head1_data, grant_data;
  logic [NUM_LANES-1:0]  head_valid;
  logic [NUM_LANES-1:0]  pop;
  logic                  load, grant_valid;
  lane_t                 grant;

  logic [DATA_WIDTH-1:0] data_q;
  lane_t                 lane_q, pref_q;
  logic                  valid_q;

  lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .in_data_i    (I_0_data),
    .in_valid_i   (I_0_valid),
    .in_ready_o   (I_0_ready),
    .head_data_o  (head0_data),
    .head_valid_o (head_valid[0]),
    .pop_i        (pop[0])
  );

  lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .in_data_i    (I_1_data),
    .in_valid_i   (I_1_valid),
    .in_ready_o   (I_1_ready),
    .head_data_o  (head1_data),
    .head_valid_o (head_valid[1]),
    .pop_i        (pop[1])
  );

  // Round-robin: pref_q only matters when both heads compete.
  always_comb begin
    load        = !valid_q || O_ready;
    grant_valid = head_valid[0] || head_valid[1];
    grant       = pref_q;
    if (head_valid[0] && !head_valid[1]) begin
      grant = LANE0;
    end else if (!head_valid[0] && head_valid[1]) begin
      grant = LANE1;
    end
    grant_data = (grant == LANE1) ? head1_data : head0_data;
    pop[0]     = load && grant_valid && (grant == LANE0);
    pop[1]     = load && grant_valid && (grant == LANE1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q  <= '0;
      lane_q  <= LANE0;
      valid_q <= 1'b0;
      pref_q  <= LANE0;
    end else if (load) begin
      if (grant_valid) begin
        data_q  <= grant_data;
        lane_q  <= grant;
        valid_q <= 1'b1;
        pref_q  <= other_lane(grant);
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign O_data  = data_q;
  assign O_lane  = lane_q;
  assign O_valid = valid_q;

endmodule

// File: tb/tb_lane_merge_arbiter.sv
// tb/tb_lane_merge_arbiter.sv - directed scoreboard bench for lane_merge_arbiter
module tb_lane_merge_arbiter;
  import lane_merge_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] I_0_data, I_1_data, O_data;
  logic       I_0_valid, I_0_ready, I_1_valid, I_1_ready;
  logic       O_lane, O_valid, O_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n0, n1;

  logic [4:0] q0 [$];
  logic [4:0] q1 [$];
  beat_t      seen [$];
  int         seen_cyc [$];
  logic       hs0, hs1, hso;
  logic [4:0] exp_d;

  lane_merge_arbiter #(.DATA_WIDTH(5), .DEPTH(2)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .I_0_data  (I_0_data),
    .I_0_valid (I_0_valid),
    .I_0_ready (I_0_ready),
    .I_1_data  (I_1_data),
    .I_1_valid (I_1_valid),
    .I_1_ready (I_1_ready),
    .O_data    (O_data),
    .O_lane    (O_lane),
    .O_valid   (O_valid),
    .O_ready   (O_ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples the handshakes that the next rising edge will complete, then
  // advances past that edge. Input beats feed per-lane expected queues;
  // output beats are checked against the queue of their reported lane.
  task automatic cycle();
    @(negedge CLK);
    hs0 = 1'b0;
    hs1 = 1'b0;
    hso = 1'b0;
    if (RESET) begin
      q0.delete();
      q1.delete();
    end else begin
      if (I_0_valid && I_0_ready) begin
        q0.push_back(I_0_data);
        hs0 = 1'b1;
      end
      if (I_1_valid && I_1_ready) begin
        q1.push_back(I_1_data);
        hs1 = 1'b1;
      end
      if (O_valid && O_ready) begin
        hso = 1'b1;
        seen.push_back(beat_t'{data: O_data, lane: lane_t'(O_lane)});
        seen_cyc.push_back(cyc);
        if (O_lane == 1'b0) begin
          chk("lane0_beat_expected", 32'(q0.size() != 0), 32'd1);
          if (q0.size() != 0) begin
            exp_d = q0.pop_front();
            chk("lane0_out_data", 32'(O_data), 32'(exp_d));
          end
        end else begin
          chk("lane1_beat_expected", 32'(q1.size() != 0), 32'd1);
          if (q1.size() != 0) begin
            exp_d = q1.pop_front();
            chk("lane1_out_data", 32'(O_data), 32'(exp_d));
          end
        end
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  initial begin
    // Reset with valids asserted
    RESET = 1'b1; O_ready = 1'b1;
    I_0_valid = 1'b1; I_0_data = 5'h0a;
    I_1_valid = 1'b1; I_1_data = 5'h15;
    repeat (3) cycle();
    chk("rst_o_valid", 32'(O_valid), 32'd0);
    chk("rst_o_data", 32'(O_data), 32'd0);
    chk("rst_o_lane", 32'(O_lane), 32'd0);
    chk("rst_i0_ready", 32'(I_0_ready), 32'd0);
    chk("rst_i1_ready", 32'(I_1_ready), 32'd0);
    RESET = 1'b0; I_0_valid = 1'b0; I_1_valid = 1'b0;
    #1;
    chk("i0_ready_before_edge", 32'(I_0_ready), 32'd0);
    cycle();
    chk("i0_ready_after_rst", 32'(I_0_ready), 32'd1);
    chk("i1_ready_after_rst", 32'(I_1_ready), 32'd1);

    // Single beat on lane 1
    I_1_data = 5'h13; I_1_valid = 1'b1;
    cycle();
    I_1_valid = 1'b0;
    chk("single_no_bypass", 32'(O_valid), 32'd0);
    cycle();
    chk("single_valid", 32'(O_valid), 32'd1);
    chk("single_data", 32'(O_data), 32'h13);
    chk("single_lane", 32'(O_lane), 32'd1);
    cycle();
    chk("single_xfer", 32'(hso), 32'd1);
    chk("single_drained", 32'(O_valid), 32'd0);

    // Both lanes saturated
    seen.delete(); seen_cyc.delete();
    n0 = 0; n1 = 0;
    I_0_valid = 1'b1; I_0_data = 5'd0;
    I_1_valid = 1'b1; I_1_data = 5'd16;
    for (int k = 0; k < 100 && seen.size() < 16; k++) begin
      cycle();
      if (hs0) n0++;
      if (hs1) n1++;
      I_0_valid = (n0 < 8); I_0_data = 5'(n0);
      I_1_valid = (n1 < 8); I_1_data = 5'(16 + n1);
    end
    I_0_valid = 1'b0; I_1_valid = 1'b0;
    chk("sat_count", 32'(seen.size()), 32'd16);
    for (int k = 0; k < seen.size(); k++)
      chk($sformatf("sat_lane_%0d", k), 32'(seen[k].lane), 32'(k % 2));
    if (seen.size() == 16)
      chk("sat_rate", 32'(seen_cyc[15] - seen_cyc[0]), 32'd15);

    // Back-pressure on lane 0
    O_ready = 1'b0;
    seen.delete();
    n0 = 0; I_0_valid = 1'b1; I_0_data = 5'd1;
    repeat (5) begin
      cycle();
      if (hs0) n0++;
      I_0_data = 5'(1 + n0);
    end
    chk("bp_accepted", 32'(n0), 32'd3);
    chk("bp_ready_low", 32'(I_0_ready), 32'd0);
    chk("bp_out_valid", 32'(O_valid), 32'd1);
    chk("bp_out_head", 32'(O_data), 32'd1);
    O_ready = 1'b1;
    for (int k = 0; k < 50 && (n0 < 4 || seen.size() < 4); k++) begin
      cycle();
      if (hs0) n0++;
      I_0_valid = (n0 < 4); I_0_data = 5'(1 + n0);
    end
    I_0_valid = 1'b0;
    chk("bp_total", 32'(seen.size()), 32'd4);
    for (int k = 0; k < seen.size(); k++)
      chk($sformatf("bp_order_%0d", k), 32'(seen[k].data), 32'(k + 1));

    // Stall stability; pref points at lane 1 after the lane-0-only run
    O_ready = 1'b0;
    I_0_data = 5'd9; I_0_valid = 1'b1;
    I_1_data = 5'd7; I_1_valid = 1'b1;
    cycle();
    I_0_valid = 1'b0; I_1_valid = 1'b0;
    cycle();
    chk("stall_valid", 32'(O_valid), 32'd1);
    repeat (2) begin
      cycle();
      chk("stall_no_xfer", 32'(hso), 32'd0);
      chk("stall_data", 32'(O_data), 32'd7);
      chk("stall_lane", 32'(O_lane), 32'd1);
    end
    O_ready = 1'b1;
    cycle();
    chk("stall_xfer", 32'(hso), 32'd1);
    chk("stall_next_data", 32'(O_data), 32'd9);
    chk("stall_next_lane", 32'(O_lane), 32'd0);
    cycle();
    chk("stall_drained", 32'(O_valid), 32'd0);

    // Mid-stream reset with pref left at lane 1
    O_ready = 1'b0;
    n0 = 0; I_0_valid = 1'b1; I_0_data = 5'd20;
    repeat (3) begin
      cycle();
      if (hs0) n0++;
      I_0_data = 5'(20 + n0);
    end
    I_0_valid = 1'b0;
    I_1_valid = 1'b1; I_1_data = 5'd25;
    repeat (3) cycle();
    I_1_valid = 1'b0;
    chk("mr_i1_full", 32'(I_1_ready), 32'd0);
    chk("mr_out_lane0", 32'(O_lane), 32'd0);
    RESET = 1'b1; O_ready = 1'b1;
    cycle();
    chk("mr_rst_valid", 32'(O_valid), 32'd0);
    chk("mr_rst_ready", 32'(I_0_ready), 32'd0);
    RESET = 1'b0;
    repeat (6) begin
      cycle();
      chk("mr_no_out_valid", 32'(O_valid), 32'd0);
      chk("mr_no_out_xfer", 32'(hso), 32'd0);
    end
    I_0_data = 5'd3; I_0_valid = 1'b1;
    I_1_data = 5'd4; I_1_valid = 1'b1;
    cycle();
    I_0_valid = 1'b0; I_1_valid = 1'b0;
    cycle();
    chk("mr_pref_lane", 32'(O_lane), 32'd0);
    chk("mr_pref_data", 32'(O_data), 32'd3);
    repeat (3) cycle();
    chk("final_q0_empty", 32'(q0.size()), 32'd0);
    chk("final_q1_empty", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_merge_arbiter.md
# lane_merge_arbiter

Consumes the two 5-bit ready/valid output lanes of the delay-unit stage (OUTPUT_0, OUTPUT_1) and merges them onto one ready/valid stream tagged with the source lane. Each lane is buffered in a small FIFO, a round-robin arbiter picks between the lane heads, and a registered output stage drives the merged stream. The block sits directly downstream of the delay unit and preserves per-lane order.

## Interface
- DATA_WIDTH, 5, payload width per beat
- DEPTH, 2, per-lane FIFO depth; must be a power of two and at least 2
- CLK  in  1  single clock; all state updates on the rising edge
- RESET  in  1  synchronous, active-high reset (decided: one clock; reset synchronous and active-high)
- I_0_data  in  DATA_WIDTH  lane 0 payload
- I_0_valid  in  1  lane 0 valid
- I_0_ready  out  1  lane 0 ready
- I_1_data / I_1_valid / I_1_ready  in/in/out  DATA_WIDTH/1/1  lane 1, same semantics as lane 0
- O_data  out  DATA_WIDTH  merged payload
- O_lane  out  1  source lane of O_data (0 or 1)
- O_valid  out  1  merged valid
- O_ready  in  1  merged ready

## Operation
- Transfer on any channel occurs on a rising edge where valid and ready are both high.
- Per-lane FIFO: registered occupancy count of width $clog2(DEPTH+1).
  - I_k_ready is a register equal to (count_k != DEPTH). It has no combinational path from O_ready or I_k_valid.
  - Push on I_k_valid && I_k_ready.
- Output register holds {O_data, O_lane, O_valid}. It loads when it is empty (!O_valid) or being drained (O_valid && O_ready). On a load, exactly one non-empty lane head is popped.
- Round-robin arbitration uses a pointer `pref`, reset to lane 0:
  - Both heads non-empty: grant `pref`; then pref <= other lane.
  - Only one head non-empty: grant that lane; then pref <= the other lane.
  - Both heads empty: no load. If draining, O_valid <= 0 and pref is unchanged.
- No bypass. An empty FIFO cannot be pushed and popped in the same cycle; the head becomes visible one cycle after the push.
- A full FIFO that is popped in cycle t raises I_k_ready at cycle t+1. The same-edge push is refused, because ready was low.
- While O_valid && !O_ready, O_data and O_lane must stay stable and no pop occurs.
- Order within a lane is preserved. Lanes are interleaved only by the arbiter.
- Reset: both FIFOs are emptied. O_valid=0, O_data=0, O_lane=0, pref=0. I_0_ready=I_1_ready=0 during reset and 1 from the first edge after RESET falls.
- Reset mid-operation: all buffered beats are discarded and no output handshake completes on the reset edge.

## Timing
- Minimum latency is 2 edges. A beat pushed on edge e enters the output register on edge e+1, and O_valid is visible after edge e+1. It can complete on edge e+2 if O_ready is high.
- Sustained throughput is 1 beat/cycle on O when O_ready is held high and either lane keeps supply.
- With both lanes saturated, the merged stream alternates lanes strictly (0,1,0,1…). Each lane then sees 1 beat per 2 cycles, provided DEPTH>=2.
- Back-pressure: with O_ready held low, each lane accepts DEPTH beats, and one more beat total sits in the output register. I_k_ready falls on the edge that fills that lane's FIFO.

## Structure
- Shared package `lane_merge_pkg`:
  - NUM_LANES=2
  - typedef lane_t (1-bit enum LANE0/LANE1)
  - typedef beat_t struct {data, lane}
- Sub-module `lane_fifo`:
  - parameters DATA_WIDTH and DEPTH
  - synchronous reset; registered ready (not full); head data/valid outputs; pop input
  - instantiated twice
- The arbiter and output register are in the top module.

## Test plan
- Reset then idle: hold RESET 3 cycles with I_*_valid=1 -> O_valid=0, O_data=0, O_lane=0, I_*_ready=0. After RESET falls, I_*_ready=1 on the next cycle.
- Single beat: push lane 1 data 5'h13 at edge e, O_ready=1 -> O_valid high after e+1 with O_data=5'h13, O_lane=1; transfer completes at e+2.
- Both lanes saturated, O_ready=1: lane 0 sends 0..7, lane 1 sends 16..23 -> output alternates lanes starting with lane 0, order preserved within each lane, one beat per cycle.
- Back-pressure: O_ready=0, lane 0 streams 1,2,3,4 -> only 1,2,3 are accepted (DEPTH=2 plus the output register), I_0_ready falls. Raise O_ready -> 1,2,3 emerge in order and 4 is accepted after ready rises.
- Stall stability: O_valid=1 with O_ready toggling 0,0,1 -> O_data/O_lane unchanged until the transfer edge.
- Mid-stream reset: lane FIFOs holding 2 beats each, pulse RESET 1 cycle -> all beats dropped, none appear on O afterwards, pref restarts at lane 0.
